// File: rtl/jk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jk_pkg                                                          |
// | Brief    : Shared op/state types, defaults and op-to-J/K mapping.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package jk_pkg;

    localparam int c_DEF_FIFO_DEPTH = 4;
    localparam int c_DEF_LEN_W      = 8;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Returns {j, k}.
    function automatic logic [1:0] op_to_jk(input op_e op);
        logic [1:0] jk;
        jk = 2'b00;
        case (op)
            OP_HOLD:   jk = 2'b00;
            OP_SET:    jk = 2'b10;
            OP_CLEAR:  jk = 2'b01;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_stim_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jk_stim_driver_if                                               |
// | Brief    : Command valid/ready handshake into the J/K stimulus driver.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface jk_stim_driver_if #(
    parameter int LEN_W = jk_pkg::c_DEF_LEN_W
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_op, output cmd_len, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_len, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jk_cmd_fifo                                                     |
// | Brief    : Synchronous command FIFO with push/pop and occupancy level.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]    c_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]  c_PINC = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign full     = (r_level == c_FULL);
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PINC;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/jk_stim_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jk_stim_driver                                                  |
// | Brief    : Queued J/K stimulus sequencer with a JK reference checker.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jk_stim_driver
    import jk_pkg::*;
#(
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int LEN_W      = c_DEF_LEN_W
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    jk_stim_driver_if.slave                    cmd,
    output logic                               j,
    output logic                               k,
    input  wire logic                          fsm_out,
    input  wire logic                          chk_en,
    output logic                               exp_out,
    output logic                               err,
    input  wire logic                          err_clr,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int               c_DW  = 2 + LEN_W;
    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [c_DW-1:0]  w_head;
    op_e              w_head_op;
    logic [LEN_W-1:0] w_head_len;

    state_e           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_j, r_k, w_j_nxt, w_k_nxt;
    logic             r_exp, r_err;

    assign cmd.cmd_ready = !w_full;
    assign w_push        = cmd.cmd_valid && !w_full;
    assign w_head_op     = op_e'(w_head[c_DW-1 -: 2]);
    assign w_head_len    = w_head[LEN_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_DW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({cmd.cmd_op, cmd.cmd_len}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    // r_cnt holds remaining cycles minus one; a zero length wraps to 2^LEN_W cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop                = 1'b1;
                    {w_j_nxt, w_k_nxt}   = op_to_jk(w_head_op);
                    w_cnt_nxt            = w_head_len - c_ONE;
                    w_state_nxt          = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (!w_empty) begin
                    w_pop                = 1'b1;
                    {w_j_nxt, w_k_nxt}   = op_to_jk(w_head_op);
                    w_cnt_nxt            = w_head_len - c_ONE;
                end else begin
                    w_j_nxt     = 1'b0;
                    w_k_nxt     = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_j_nxt     = 1'b0;
                w_k_nxt     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Reference JK flop fed by our own registered drive; mismatch set beats clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exp <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case ({r_j, r_k})
                2'b10:   r_exp <= 1'b1;
                2'b01:   r_exp <= 1'b0;
                2'b11:   r_exp <= ~r_exp;
                default: r_exp <= r_exp;
            endcase
            if (chk_en && (fsm_out != r_exp)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign j       = r_j;
    assign k       = r_k;
    assign exp_out = r_exp;
    assign err     = r_err;
    assign busy    = (r_state == ST_DRIVE);
endmodule
`default_nettype wire

// File: tb/tb_jk_stim_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jk_stim_driver                                               |
// | Brief    : Self-checking bench for jk_stim_driver with a JK reference flop.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_jk_stim_driver;
    localparam int DEPTH = 4;
    localparam int LW    = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       j, k, exp_out, err, busy;
    logic       fsm_out;
    logic       chk_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       fsm_force = 1'b0;
    logic       jkq;
    logic [2:0] fifo_level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_stim_driver_if #(.LEN_W(LW)) cmd_if ();

    jk_stim_driver #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd_if.slave),
        .j          (j),
        .k          (k),
        .fsm_out    (fsm_out),
        .chk_en     (chk_en),
        .exp_out    (exp_out),
        .err        (err),
        .err_clr    (err_clr),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    // Downstream JK flip-flop driven by the DUT's j/k.
    always @(posedge clk) begin
        if (!reset_n)       jkq <= 1'b0;
        else if (j && !k)   jkq <= 1'b1;
        else if (!j && k)   jkq <= 1'b0;
        else if (j && k)    jkq <= ~jkq;
    end
    assign fsm_out = fsm_force ? 1'b0 : jkq;

    function automatic logic [1:0] ref_jk(input logic [1:0] op);
        case (op)
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            2'd3:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic offer(input logic v, input logic [1:0] op, input logic [LW-1:0] len);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_len   = len;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; chk_en = 1'b0; err_clr = 1'b0; fsm_force = 1'b0;
        offer(1'b0, 2'd0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        offer(1'b1, 2'd1, 8'd3);
        @(negedge clk);
        checks++; if ({j, k} !== 2'b00)    begin failures++; $display("FAIL reset_jk: got %b want 00", {j, k}); end
        checks++; if (exp_out !== 1'b0)    begin failures++; $display("FAIL reset_exp: got %b want 0", exp_out); end
        checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        reset_n = 1'b1;
        offer(1'b0, 2'd0, 8'd0);
        @(negedge clk);
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_no_accept: level %0d want 0", fifo_level); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_no_drive: busy %b want 0", busy); end
    endtask

    task automatic test_single_set();
        do_reset();
        offer(1'b1, 2'd1, 8'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) offer(1'b0, 2'd0, 8'd0);
            checks++;
            if ({j, k} !== ((i >= 1 && i <= 3) ? 2'b10 : 2'b00)) begin
                failures++; $display("FAIL single_jk[%0d]: got %b want %b", i, {j, k}, ((i >= 1 && i <= 3) ? 2'b10 : 2'b00));
            end
            checks++;
            if (busy !== (i >= 1 && i <= 3)) begin
                failures++; $display("FAIL single_busy[%0d]: got %b want %b", i, busy, (i >= 1 && i <= 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] jk_seq [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        logic       ex_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        chk_en = 1'b1;
        offer(1'b1, 2'd1, 8'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 6) begin
                checks++;
                if ({j, k} !== jk_seq[i-1]) begin failures++; $display("FAIL b2b_jk[%0d]: got %b want %b", i, {j, k}, jk_seq[i-1]); end
            end
            if (i >= 2 && i <= 6) begin
                checks++;
                if (exp_out !== ex_seq[i-2]) begin failures++; $display("FAIL b2b_exp[%0d]: got %b want %b", i, exp_out, ex_seq[i-2]); end
            end
            if (i == 0) offer(1'b1, 2'd2, 8'd2);
            if (i == 1) offer(1'b1, 2'd3, 8'd1);
            if (i == 2) offer(1'b0, 2'd0, 8'd0);
        end
        checks++; if (err !== 1'b0)  begin failures++; $display("FAIL b2b_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy %b want 0", busy); end
        chk_en = 1'b0;
    endtask

    task automatic test_full();
        int lvl_seq [10] = '{1, 1, 2, 3, 4, 4, 3, 4, 4, 4};
        do_reset();
        offer(1'b1, 2'd1, 8'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_level !== 3'(lvl_seq[i])) begin failures++; $display("FAIL full_level[%0d]: got %0d want %0d", i, fifo_level, lvl_seq[i]); end
            checks++;
            if (cmd_if.cmd_ready !== (lvl_seq[i] < DEPTH)) begin
                failures++; $display("FAIL full_ready[%0d]: got %b want %b", i, cmd_if.cmd_ready, (lvl_seq[i] < DEPTH));
            end
            if (i == 7) offer(1'b0, 2'd0, 8'd0);
        end
    endtask

    task automatic test_len0();
        int busy_cnt = 0;
        int jk_bad = 0;
        do_reset();
        offer(1'b1, 2'd0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) offer(1'b0, 2'd0, 8'd0);
            if (busy === 1'b1) busy_cnt++;
            if ({j, k} !== 2'b00) jk_bad++;
        end
        checks++; if (busy_cnt != 256) begin failures++; $display("FAIL len0_busy: got %0d cycles want 256", busy_cnt); end
        checks++; if (jk_bad != 0)     begin failures++; $display("FAIL len0_jk: got %0d nonzero cycles want 0", jk_bad); end
    endtask

    task automatic test_err();
        do_reset();
        chk_en = 1'b1; fsm_force = 1'b1;
        offer(1'b1, 2'd1, 8'd4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) offer(1'b0, 2'd0, 8'd0);
            if (i == 2) begin checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_before: got %b want 0", err); end end
            if (i == 3) begin checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", err); end end
            if (i == 4) begin
                checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
                fsm_force = 1'b0; err_clr = 1'b1;
            end
            if (i == 5) begin
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err); end
                fsm_force = 1'b1;
            end
            if (i == 6) begin
                checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set_wins: got %b want 1", err); end
                fsm_force = 1'b0;
            end
            if (i == 7) begin
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear2: got %b want 0", err); end
            end
        end
        err_clr = 1'b0; chk_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        offer(1'b1, 2'd1, 8'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) offer(1'b0, 2'd0, 8'd0);
        end
        checks++; if (busy !== 1'b1 || fifo_level !== 3'd2) begin
            failures++; $display("FAIL mid_pre: busy %b level %0d want 1/2", busy, fifo_level);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({j, k} !== 2'b00)    begin failures++; $display("FAIL mid_jk: got %b want 00", {j, k}); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
        checks++; if (err !== 1'b0 || exp_out !== 1'b0) begin
            failures++; $display("FAIL mid_chk: err %b exp %b want 0/0", err, exp_out);
        end
        reset_n = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if ({j, k} !== 2'b00 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL mid_after: got %0d active cycles want 0", bad); end
        end
    endtask

    // Each accepted command gets start edge s = max(push_edge+1, previous end);
    // it covers edges s..s+len-1 and is queued while push_edge <= e < s.
    task automatic test_random();
        int         s_q[$], l_q[$], p_q[$];
        logic [1:0] o_q[$];
        int         last_end = 0;
        logic       m_exp = 1'b0;
        logic [1:0] prev_jk = 2'b00;
        do_reset();
        chk_en = 1'b1;
        for (int e = 0; e < 400; e++) begin
            logic [1:0] m_jk;
            logic       m_busy;
            int         m_lvl;
            if (e > 0) begin
                case (prev_jk)
                    2'b10:   m_exp = 1'b1;
                    2'b01:   m_exp = 1'b0;
                    2'b11:   m_exp = ~m_exp;
                    default: m_exp = m_exp;
                endcase
            end
            m_jk = 2'b00; m_busy = 1'b0; m_lvl = 0;
            for (int n = 0; n < s_q.size(); n++) begin
                if (s_q[n] <= e && e < s_q[n] + l_q[n]) begin m_jk = ref_jk(o_q[n]); m_busy = 1'b1; end
                if (p_q[n] <= e && s_q[n] > e) m_lvl++;
            end
            checks++; if ({j, k} !== m_jk)      begin failures++; $display("FAIL rnd_jk[%0d]: got %b want %b", e, {j, k}, m_jk); end
            checks++; if (busy !== m_busy)      begin failures++; $display("FAIL rnd_busy[%0d]: got %b want %b", e, busy, m_busy); end
            checks++; if (fifo_level !== 3'(m_lvl)) begin failures++; $display("FAIL rnd_level[%0d]: got %0d want %0d", e, fifo_level, m_lvl); end
            checks++; if (cmd_if.cmd_ready !== (m_lvl < DEPTH)) begin
                failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", e, cmd_if.cmd_ready, (m_lvl < DEPTH));
            end
            checks++; if (exp_out !== m_exp)    begin failures++; $display("FAIL rnd_exp[%0d]: got %b want %b", e, exp_out, m_exp); end
            checks++; if (err !== 1'b0)         begin failures++; $display("FAIL rnd_err[%0d]: got %b want 0", e, err); end
            prev_jk = m_jk;
            if (e < 340 && $urandom_range(0, 1) == 1) begin
                int         len = int'($urandom_range(1, 7));
                logic [1:0] op  = 2'($urandom_range(0, 3));
                offer(1'b1, op, len[LW-1:0]);
                if (m_lvl < DEPTH) begin
                    int s = (e + 2 > last_end) ? e + 2 : last_end;
                    p_q.push_back(e + 1); s_q.push_back(s); l_q.push_back(len); o_q.push_back(op);
                    last_end = s + len;
                end
            end else begin
                offer(1'b0, 2'd0, 8'd0);
            end
            @(negedge clk);
        end
        chk_en = 1'b0;
    endtask

    initial begin
        offer(1'b0, 2'd0, 8'd0);
        test_reset();
        test_single_set();
        test_back_to_back();
        test_full();
        test_len0();
        test_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
